// File: rtl/flow_pulse_meter_pkg.sv
// Purpose : shared types and defaults for the flow pulse meter (FSM state enum, default sizes, gate-counter width helper).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package flow_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int GATE_CYCLES_DEFAULT = 50_000_000;
    localparam int CNT_W_DEFAULT       = 16;

    // Width of a counter that runs 0 .. gate_cycles-1.
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/flow_pulse_meter_if.sv
// Purpose : result channel from the pulse meter to the control FSM (count, status flags, valid/ready).
// Latency : n/a (wires only).
// Backpressure: freq_ready from the consumer; the producer holds freq_valid/freq_out/saturated until accepted.
// Ports   : master = meter (drives freq_out, freq_valid, saturated, overrun; reads freq_ready),
//           slave  = consumer (the reverse).
interface flow_pulse_meter_if
    import flow_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [CNT_W-1:0] freq_out;
    logic             freq_valid;
    logic             freq_ready;
    logic             saturated;
    logic             overrun;

    modport master (
        output freq_out,
        output freq_valid,
        output saturated,
        output overrun,
        input  freq_ready
    );

    modport slave (
        input  freq_out,
        input  freq_valid,
        input  saturated,
        input  overrun,
        output freq_ready
    );
endinterface

// File: rtl/flow_pulse_meter_pulse_edge_sync.sv
// Purpose : synchronise the async pulse input, optionally debounce it, and flag each rising edge.
// Latency : rise is asserted SYNC_STAGES cycles after pulse_in is first sampled high
//           (+DEB_CYCLES when FLOW_METER_DEBOUNCE_EN is defined).
// Backpressure: none; free-running, one rise per detected edge.
// Ports   : clk, reset (sync, active high), pulse_in (async), rise (1-cycle strobe).
// Config  : FLOW_METER_DEBOUNCE_EN inserts a DEB_CYCLES stable-level filter after the synchroniser.
module pulse_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic rise
);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("pulse_edge_sync: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   level_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
        end
    end

`ifdef FLOW_METER_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt;
    logic             filt;

    // deb_cnt counts consecutive cycles where the synced input disagrees
    // with the filtered level; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt    <= 1'b0;
            deb_cnt <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            filt    <= ~filt;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign level = filt;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/flow_pulse_meter.sv
// Purpose : count rising edges of a slow sensor pulse train over back-to-back GATE_CYCLES windows.
// Latency : result is presented on the edge after the last gate cycle; pulse_in edge to count update is SYNC_STAGES+1 cycles.
// Backpressure: result held until freq_ready; a new window end overwrites an unaccepted result and sets sticky overrun.
// Ports   : clk, reset (sync, active high), enable (runs windows while high), pulse_in (async),
//           res (master modport: freq_out, freq_valid, freq_ready, saturated, overrun).
// Config  : FLOW_METER_DEBOUNCE_EN enables the input debounce filter in pulse_edge_sync.
module flow_pulse_meter
    import flow_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pulse_in,
    flow_pulse_meter_if.master  res
);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("flow_pulse_meter: GATE_CYCLES must be >= 2");
    end

    localparam int                GATE_W    = gate_cnt_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    state_t             state, state_nxt;
    logic [GATE_W-1:0]  gate_cnt, gate_nxt;
    logic [CNT_W-1:0]   pulse_cnt, pulse_nxt, pulse_inc;
    logic               sat_q, sat_nxt, sat_inc;
    logic               win_end;
    logic               rise;

    logic [CNT_W-1:0]   freq_out_q;
    logic               valid_q;
    logic               sat_out_q;
    logic               ovr_q;

    pulse_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_edge (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gate_nxt  = gate_cnt;
        pulse_nxt = pulse_cnt;
        sat_nxt   = sat_q;
        win_end   = 1'b0;

        // Count including this cycle's rise; the sat flag marks an increment
        // attempted past all-ones rather than merely reaching it.
        pulse_inc = pulse_cnt;
        sat_inc   = sat_q;
        if (rise) begin
            if (&pulse_cnt) begin
                sat_inc = 1'b1;
            end else begin
                pulse_inc = pulse_cnt + CNT_W'(1);
            end
        end

        case (state)
            IDLE: begin
                gate_nxt  = '0;
                pulse_nxt = '0;
                sat_nxt   = 1'b0;
                if (enable) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // Window end wins over enable dropping in the same cycle,
                // so a completed window always reports.
                if (gate_cnt == GATE_LAST) begin
                    win_end   = 1'b1;
                    gate_nxt  = '0;
                    pulse_nxt = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = enable ? MEASURE : IDLE;
                end else if (!enable) begin
                    gate_nxt  = '0;
                    pulse_nxt = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    gate_nxt  = gate_cnt + GATE_W'(1);
                    pulse_nxt = pulse_inc;
                    sat_nxt   = sat_inc;
                end
            end
            default: begin
                gate_nxt  = '0;
                pulse_nxt = '0;
                sat_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt   <= '0;
            pulse_cnt  <= '0;
            sat_q      <= 1'b0;
            freq_out_q <= '0;
            valid_q    <= 1'b0;
            sat_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            gate_cnt  <= gate_nxt;
            pulse_cnt <= pulse_nxt;
            sat_q     <= sat_nxt;
            if (win_end) begin
                // A same-cycle accept consumes the old result, so only an
                // unaccepted overwrite counts as overrun.
                freq_out_q <= pulse_inc;
                sat_out_q  <= sat_inc;
                valid_q    <= 1'b1;
                if (valid_q && !res.freq_ready) begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && res.freq_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign res.freq_out   = freq_out_q;
    assign res.freq_valid = valid_q;
    assign res.saturated  = sat_out_q;
    assign res.overrun    = ovr_q;

endmodule

// File: doc/flow_pulse_meter.md
Name: flow_pulse_meter

Overview:
- Measures the rate of an external pulse train, e.g. a water-flow or rain-gauge sensor, by counting rising edges over a fixed gate window of clock cycles.
- Sits at the sensor input of the irrigation controller.
- It is the measuring counterpart of the clock dividers: dividers generate slow periodic signals, this block reads one.
- Results go to the control FSM through a valid/ready handshake.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); minimum 2.
- CNT_W, 16, width of the pulse count and the result.
- SYNC_STAGES, 2, synchronizer flops on pulse_in; minimum 2.
- DEB_CYCLES, 8, stable cycles required by the debounce filter (used only with the optional feature).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; high runs back-to-back gate windows.
- pulse_in  in  1  asynchronous sensor pulse input.
- freq_out  out  CNT_W  rising-edge count of the last completed window.
- freq_valid  out  1  result available; held until accepted.
- freq_ready  in  1  consumer accepts the result when freq_valid and freq_ready are both high on a clk edge.
- saturated  out  1  the result in freq_out clipped at 2^CNT_W-1.
- overrun  out  1  sticky; an unaccepted result was overwritten.

Behaviour:
- Clock and reset:
  - Everything is clocked on the rising edge of clk.
  - While reset is high, at the next edge: all outputs go to 0, the state goes to IDLE, the gate and pulse counters go to 0, and the synchronizer and edge-history flops go to 0.
- Input path:
  - pulse_in passes through SYNC_STAGES flops; rise = synced & ~prev.
  - Latency from a pulse_in transition to the count update is SYNC_STAGES+1 cycles.
- FSM states: IDLE, MEASURE.
  - IDLE: counters held at 0; edges ignored. enable=1 causes a transition to MEASURE on the next edge, with gate_cnt=0.
  - MEASURE: gate_cnt increments every cycle. A rise increments pulse_cnt, saturating at all-ones, and sets an internal sat flag on the attempted increment past all-ones.
  - Window end (gate_cnt==GATE_CYCLES-1):
    - A rise in that same cycle is included.
    - freq_out <= final count; saturated <= sat flag; freq_valid <= 1.
    - Counters and sat flag clear.
    - Stay in MEASURE if enable=1, else go to IDLE. No dead cycle between windows.
  - enable falling mid-window: abort, go to IDLE, clear counters, produce no result. freq_out, freq_valid and saturated keep their values.
- Handshake:
  - freq_valid holds and freq_out/saturated are stable until accepted.
  - Acceptance without a new result in the same cycle: freq_valid <= 0 on the next edge.
  - Window end and acceptance in the same cycle: the new result loads, freq_valid stays 1, no overrun.
  - Window end while freq_valid=1 and freq_ready=0: the new result overwrites the old one and overrun <= 1. overrun clears only on reset.
- Boundaries:
  - A pulse_in level held high across reset release counts as one rise once MEASURE is entered, because the sync flops reset to 0.
  - Full-rate input (toggling every cycle) is beyond spec. Edges closer than 2 cycles apart may merge; no error is flagged.

Optional Feature:
- Macro: FLOW_METER_DEBOUNCE_EN.
- Defined:
  - A debounce filter sits after the synchronizer.
  - The filtered level changes only after the synced input differs from it for DEB_CYCLES consecutive cycles.
  - rise is taken from the filtered level.
  - Added latency is DEB_CYCLES cycles.
  - The filter resets to 0.
- Undefined: no filter; rise is taken directly from the synchronizer. DEB_CYCLES is ignored.

Decomposition:
- Package flow_meter_pkg:
  - state enum type (IDLE, MEASURE);
  - default constants for GATE_CYCLES and CNT_W;
  - the gate-counter width function clog2(GATE_CYCLES).
- One sub-module: pulse_edge_sync, containing the synchronizer, the optional debounce filter and the rising-edge detector, with 1-bit output rise.

Test Plan (GATE_CYCLES=100, CNT_W=4, SYNC_STAGES=2, debounce off unless noted):
- Reset and idle:
  - Stimulus: reset then enable=0, toggle pulse_in for 300 cycles.
  - Required: freq_valid=0, freq_out=0, saturated=0, overrun=0 throughout.
- Basic count:
  - Stimulus: enable=1, 7 pulses 4 cycles high / 6 low inside the window, freq_ready=1.
  - Required: freq_valid high for exactly 1 cycle, 100 cycles after MEASURE entry, with freq_out=7.
- Saturation:
  - Stimulus: 20 pulses in one window.
  - Required: freq_out=15, saturated=1. Next window with 3 pulses gives freq_out=3, saturated=0.
- Backpressure:
  - Stimulus: freq_ready=0 across two windows of 5 then 9 pulses.
  - Required: freq_out=5 held until the second window end, then freq_out=9 and overrun=1.
  - Then freq_ready=1 for 1 cycle: freq_valid drops, overrun stays 1.
- Simultaneous accept and window end:
  - Stimulus: assert freq_ready exactly on the window-end cycle.
  - Required: new count loaded, freq_valid stays 1, overrun=0.
- Abort and debounce:
  - Abort stimulus: drop enable at gate_cnt=50. Required: no freq_valid, previous freq_out retained.
  - Debounce stimulus: with FLOW_METER_DEBOUNCE_EN and DEB_CYCLES=8, apply 3-cycle glitches plus 4 clean 20-cycle pulses.
  - Debounce required: freq_out=4.
